coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
//
// PURPOSE
//   Coin front-end for the turnstile credit counter. Synchronises the raw
//   coin-slot sensor and detects coin arrivals. Accumulates coin value in
//   cents and emits one credit_o pulse each time the balance covers FARE.
//   The pulse drives the counter's coin_i. Also returns the unspent
//   balance as 5-cent change pulses on request.
//
// PARAMETERS
//   FARE   100  fare in cents; multiple of 5, nonzero, < 2**BAL_W
//   BAL_W  10   balance register width in bits (max balance 2**BAL_W-1)
//
// PORTS
//   clk_i          in   1      clock
//   rst_ni         in   1      reset, asynchronous, active-low
//   coin_sense_i   in   1      raw slot sensor, async, high while coin present
//   coin_type_i    in   2      denomination, stable while coin_sense_i high:
//                              00=5c 01=10c 10=25c 11=50c
//   refund_i       in   1      refund request, synchronous level
//   credit_full_i  in   1      downstream cannot accept credit (stall)
//   credit_o       out  1      one-cycle credit pulse (to coin_i downstream)
//   change_o       out  1      one-cycle pulse per 5c returned
//   reject_o       out  1      one-cycle pulse: coin refused, not added
//   busy_o         out  1      FSM not in IDLE
//   balance_o      out  BAL_W  current balance in cents
//
// BEHAVIOUR
//   - Reset: all outputs 0; balance 0; FSM IDLE; synchroniser flops 0.
//   - Reset mid-operation (e.g. in REFUND): remaining balance is discarded.
//     Outputs go to 0 asynchronously.
//   - coin_sense_i passes through a 2-flop synchroniser and a rising-edge
//     detector.
//   - The coin event is asserted in the edge cycle E. coin_type_i is
//     sampled in cycle E.
//   - balance_o reflects the coin at E+1. Latency from the sensor edge to
//     the balance update is 3 clocks.
//   - One coin per sensor rising edge. A held-high sensor adds nothing
//     further.
//   - Coin acceptance in IDLE and CREDIT:
//     - If balance + value <= 2**BAL_W-1, the value is added.
//     - Otherwise reject_o pulses in cycle E and the balance is unchanged.
//   - Coin in REFUND: always rejected (reject_o pulse, balance unchanged).
//   - FSM states: IDLE, CREDIT, REFUND.
//     - IDLE, checked in priority order:
//       1. refund_i && balance != 0 -> REFUND.
//       2. balance >= FARE && !credit_full_i -> CREDIT.
//       3. Otherwise stay in IDLE.
//     - CREDIT: credit_o=1 for this single cycle; balance -= FARE; -> IDLE.
//       At most one credit per 2 cycles.
//     - REFUND: each cycle change_o=1 and balance -= 5. Exit to IDLE in the
//       cycle the balance reaches 0. refund_i is ignored in this state.
//   - Simultaneous coin + CREDIT subtract: the new balance is
//     balance - FARE + value. The overflow check uses the post-subtract
//     value.
//   - Comparisons and arithmetic are unsigned in BAL_W bits. The balance
//     is always a multiple of 5 and never wraps.
//   - credit_full_i is sampled only in IDLE. Once in CREDIT, the pulse
//     always completes.
//   - busy_o = (state != IDLE), registered with the state.
//
// STRUCTURE
//   - coin_pkg holds:
//     - coin_type_e (2-bit enum of the denominations)
//     - coin_value() function (type -> cents)
//     - acc_state_e enum (IDLE, CREDIT, REFUND)
//     - CHANGE_UNIT = 5
//   - Sub-module sync_edge_det: 2-flop synchroniser plus rising-edge pulse,
//     using clk_i/rst_ni. Instantiated once for coin_sense_i.
//   - The top level holds the FSM, the balance register and the
//     overflow/reject logic.
//
// TESTING (FARE=100, BAL_W=10)
//   1. Reset held, then released with no stimulus
//      -> all outputs 0; balance_o=0 for 20 cycles.
//   2. Coins 25,25,50, each with a clean sensor pulse
//      -> balance 25, 50, 100, each 3 clocks after its edge.
//      -> Then one credit_o pulse; balance_o=0; no change_o.
//   3. credit_full_i=1, coins 50x4
//      -> balance_o=200; no credit_o.
//      -> Drop credit_full_i: two credit_o pulses exactly 2 cycles apart;
//         balance_o=0.
//   4. Coins 25+10 (balance 35), then refund_i for 1 cycle
//      -> 7 consecutive change_o pulses; busy_o high 7 cycles; balance 0.
//   5. Balance 35, refund_i, then a 50c coin edge during REFUND
//      -> reject_o pulse; the change_o count is still 7; final balance 0.
//   6. credit_full_i=1, balance 1000 (20x50c), insert 50c
//      -> reject_o pulse; balance stays 1000.
//      -> Then assert rst_ni=0 mid-refund: all outputs 0 asynchronously.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin front-end: denominations, FSM states
// and the refund change unit.
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_5C  = 2'b00,
        COIN_10C = 2'b01,
        COIN_25C = 2'b10,
        COIN_50C = 2'b11
    } coin_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CREDIT = 2'b01,
        REFUND = 2'b10
    } acc_state_e;

    localparam int unsigned CHANGE_UNIT = 5;

    function automatic logic [5:0] coin_value(input coin_type_e coin_type);
        case (coin_type)
            COIN_5C:  return 6'd5;
            COIN_10C: return 6'd10;
            COIN_25C: return 6'd25;
            default:  return 6'd50;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// detector producing a single-cycle pulse in the clk_i domain.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front-end: detects coin arrivals, accumulates the balance in cents,
// issues one credit pulse per FARE covered and refunds the rest in 5c steps.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned FARE  = 100,
    parameter int unsigned BAL_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             coin_sense_i,
    input  logic [1:0]       coin_type_i,
    input  logic             refund_i,
    input  logic             credit_full_i,
    output logic             credit_o,
    output logic             change_o,
    output logic             reject_o,
    output logic             busy_o,
    output logic [BAL_W-1:0] balance_o
);

    localparam logic [BAL_W-1:0] FARE_B   = BAL_W'(FARE);
    localparam logic [BAL_W-1:0] CHANGE_B = BAL_W'(CHANGE_UNIT);
    localparam logic [BAL_W:0]   MAX_BAL  = {1'b0, {BAL_W{1'b1}}};

    acc_state_e       state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [BAL_W-1:0] base;
    logic [BAL_W-1:0] coin_val;
    logic [BAL_W:0]   sum;
    logic             coin_evt;

    sync_edge_det u_sense_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (coin_sense_i),
        .rise_o  (coin_evt)
    );

    assign coin_val = BAL_W'(coin_value(coin_type_e'(coin_type_i)));

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        base     = balance_q;
        credit_o = 1'b0;
        change_o = 1'b0;
        reject_o = 1'b0;
        sum      = '0;

        case (state_q)
            IDLE: begin
                if (refund_i && balance_q != '0) begin
                    state_d = REFUND;
                end else if (balance_q >= FARE_B && !credit_full_i) begin
                    state_d = CREDIT;
                end
            end
            CREDIT: begin
                credit_o = 1'b1;
                base     = balance_q - FARE_B;
                state_d  = IDLE;
            end
            REFUND: begin
                change_o = 1'b1;
                base     = balance_q - CHANGE_B;
                if (balance_q == CHANGE_B) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Overflow is judged against the post-subtract balance, so a coin
        // landing on a credit cycle sees the room the credit just freed.
        if (coin_evt) begin
            sum = {1'b0, base} + {1'b0, coin_val};
            if (state_q == REFUND || sum > MAX_BAL) begin
                reject_o = 1'b1;
            end else begin
                base = sum[BAL_W-1:0];
            end
        end

        balance_d = base;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            balance_q <= '0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign balance_o = balance_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed and randomized checks of coin_acceptor against a cents-level
// reference model (FARE=100, BAL_W=10).
module tb_coin_acceptor;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       coin_sense_i;
    logic [1:0] coin_type_i;
    logic       refund_i;
    logic       credit_full_i;
    logic       credit_o;
    logic       change_o;
    logic       reject_o;
    logic       busy_o;
    logic [9:0] balance_o;

    int n_checks = 0;
    int n_err    = 0;

    // Pulse monitor, sampled mid-cycle.
    int cyc = 0;
    int n_credit = 0, n_change = 0, n_reject = 0, n_busy = 0;
    int last_credit_cyc = 0, prev_credit_cyc = 0;
    int change_run = 0, last_change_run = 0;

    coin_acceptor #(.FARE(100), .BAL_W(10)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .coin_sense_i  (coin_sense_i),
        .coin_type_i   (coin_type_i),
        .refund_i      (refund_i),
        .credit_full_i (credit_full_i),
        .credit_o      (credit_o),
        .change_o      (change_o),
        .reject_o      (reject_o),
        .busy_o        (busy_o),
        .balance_o     (balance_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            cyc++;
            if (credit_o) begin
                n_credit++;
                prev_credit_cyc = last_credit_cyc;
                last_credit_cyc = cyc;
            end
            if (reject_o) n_reject++;
            if (busy_o) n_busy++;
            if (change_o) begin
                n_change++;
                change_run++;
            end else begin
                if (change_run != 0) last_change_run = change_run;
                change_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic int cents(input logic [1:0] t);
        case (t)
            2'b00:   return 5;
            2'b01:   return 10;
            2'b10:   return 25;
            default: return 50;
        endcase
    endfunction

    // Clean sensor pulse; balance is checked 3 clocks after the sensor edge.
    task automatic coin(input logic [1:0] t, input int exp_bal, input string tag);
        coin_type_i  = t;
        coin_sense_i = 1'b1;
        step(3);
        check(tag, 32'(balance_o), 32'(exp_bal));
        coin_sense_i = 1'b0;
        step(3);
    endtask

    int c0, ch0, r0, b0;
    int exp_bal, exp_credits, exp_rejects;
    logic [1:0] t;
    logic cf;

    initial begin
        rst_ni        = 1'b0;
        coin_sense_i  = 1'b0;
        coin_type_i   = 2'b00;
        refund_i      = 1'b0;
        credit_full_i = 1'b0;

        // 1: reset held, then idle with no stimulus
        step(3);
        check("reset_outputs", 32'({credit_o, change_o, reject_o, busy_o, balance_o}), 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", 32'({credit_o, change_o, reject_o, busy_o, balance_o}), 0);
        end

        // 2: 25 + 25 + 50 reaches the fare exactly
        c0 = n_credit; ch0 = n_change;
        coin(2'b10, 25, "t2_bal25");
        coin(2'b10, 50, "t2_bal50");
        coin(2'b11, 100, "t2_bal100");
        step(2);
        check("t2_credit_cnt", 32'(n_credit - c0), 1);
        check("t2_bal_after", 32'(balance_o), 0);
        check("t2_no_change", 32'(n_change - ch0), 0);

        // 3: stalled credit accumulates, then drains at one per 2 cycles
        credit_full_i = 1'b1;
        c0 = n_credit;
        for (int i = 1; i <= 4; i++) coin(2'b11, 50 * i, "t3_bal_stalled");
        check("t3_no_credit", 32'(n_credit - c0), 0);
        credit_full_i = 1'b0;
        step(6);
        check("t3_credit_cnt", 32'(n_credit - c0), 2);
        check("t3_credit_spacing", 32'(last_credit_cyc - prev_credit_cyc), 2);
        check("t3_bal_after", 32'(balance_o), 0);

        // 4: refund of 35c returns seven consecutive 5c pulses
        coin(2'b10, 25, "t4_bal25");
        coin(2'b01, 35, "t4_bal35");
        ch0 = n_change; b0 = n_busy;
        refund_i = 1'b1;
        step();
        refund_i = 1'b0;
        step(10);
        check("t4_change_cnt", 32'(n_change - ch0), 7);
        check("t4_change_run", 32'(last_change_run), 7);
        check("t4_busy_cycles", 32'(n_busy - b0), 7);
        check("t4_bal_after", 32'(balance_o), 0);

        // 5: coin arriving during refund is rejected
        coin(2'b10, 25, "t5_bal25");
        coin(2'b01, 35, "t5_bal35");
        ch0 = n_change; r0 = n_reject;
        refund_i     = 1'b1;
        coin_type_i  = 2'b11;
        coin_sense_i = 1'b1;
        step();
        refund_i = 1'b0;
        step(10);
        coin_sense_i = 1'b0;
        step(3);
        check("t5_reject_cnt", 32'(n_reject - r0), 1);
        check("t5_change_cnt", 32'(n_change - ch0), 7);
        check("t5_bal_after", 32'(balance_o), 0);

        // Randomized coins with random credit stalls against a cents model
        exp_bal = 0; exp_credits = 0; exp_rejects = 0;
        c0 = n_credit; r0 = n_reject;
        for (int i = 0; i < 30; i++) begin
            t  = 2'($urandom_range(0, 3));
            cf = ($urandom_range(0, 3) == 0);
            credit_full_i = cf;
            if (!cf) begin
                step(2 * (exp_bal / 100) + 2);
                exp_credits += exp_bal / 100;
                exp_bal     = exp_bal % 100;
            end
            if (exp_bal + cents(t) > 1023) exp_rejects++;
            else exp_bal += cents(t);
            coin(t, exp_bal, "rnd_bal_after_coin");
            if (!cf) begin
                step(2 * (exp_bal / 100) + 2);
                exp_credits += exp_bal / 100;
                exp_bal     = exp_bal % 100;
            end
            check("rnd_bal_settled", 32'(balance_o), 32'(exp_bal));
            check("rnd_credit_cnt", 32'(n_credit - c0), 32'(exp_credits));
        end
        check("rnd_reject_cnt", 32'(n_reject - r0), 32'(exp_rejects));
        ch0 = n_change;
        refund_i = 1'b1;
        step();
        refund_i = 1'b0;
        step(exp_bal / 5 + 4);
        check("rnd_refund_change", 32'(n_change - ch0), 32'(exp_bal / 5));
        check("rnd_refund_bal", 32'(balance_o), 0);

        // 6: fill to 1000 under stall, overflowing coin rejected, reset mid-refund
        credit_full_i = 1'b1;
        for (int i = 1; i <= 20; i++) coin(2'b11, 50 * i, "t6_fill");
        r0 = n_reject;
        coin(2'b11, 1000, "t6_bal_held");
        check("t6_reject_cnt", 32'(n_reject - r0), 1);
        refund_i = 1'b1;
        step(3);
        check("t6_in_refund", 32'({change_o, busy_o}), 32'(2'b11));
        rst_ni = 1'b0;
        #1;
        check("t6_async_reset", 32'({credit_o, change_o, reject_o, busy_o, balance_o}), 0);
        refund_i      = 1'b0;
        credit_full_i = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(3);
        check("t6_after_reset", 32'({credit_o, change_o, reject_o, busy_o, balance_o}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
